rv32i_mtimer: RTL and testbench
===============================

// Module: rv32i_mtimer
// PURPOSE
//  Machine timer: the producer side of the CSR file's mtime[47:0] and timer_interrupt inputs.
//  Holds a free-running 48-bit mtime and a 48-bit mtimecmp, both memory-mapped on the data bus.
//  Raises MTIP (timer_interrupt) while mtime >= mtimecmp; the CSR file exposes it as mip[7].
// PARAMETERS
//  PRESCALE      16   core clocks per mtime tick (used only with MTIMER_PRESCALE_EN; legal 1..65535)
// PORTS
//  clk              in   1   core clock, single clock domain
//  rst_n            in   1   asynchronous active-low reset
//  bus_req          in   1   access request, one cycle per access
//  bus_we           in   1   1=write, 0=read; qualified by bus_req
//  bus_addr         in   5   byte offset within the timer window; bits [1:0] ignored
//  bus_wdata        in   32  write data, full-word writes only
//  bus_rvalid       out  1   response strobe, exactly one cycle after each bus_req
//  bus_rdata        out  32  read data, valid with bus_rvalid (0 for writes and errors)
//  bus_err          out  1   undefined offset, valid with bus_rvalid
//  mtime            out  48  current time, to CSR cycle/time/instret[h]
//  timer_interrupt  out  1   MTIP, registered
// BEHAVIOUR
//  Map: 0x00 MTIME_LO[31:0] | 0x04 MTIME_HI{16'd0,[47:32]} | 0x08 MTIMECMP_LO | 0x0C MTIMECMP_HI{16'd0,[47:32]}
//       | 0x10 CTRL bit0=EN (other bits read 0, writes ignored). Any other offset -> bus_err=1, no state change.
//  Reset: mtime=0, mtimecmp=48'hFFFF_FFFF_FFFF, EN=1, bus_rvalid=0, bus_rdata=0, bus_err=0, timer_interrupt=0.
//  Handshake: no backpressure. A bus_req in cycle N is answered in cycle N+1 (rvalid=1, rdata/err registered).
//   Back-to-back requests are allowed, one response per cycle.
//  Read data reflects register state sampled in cycle N, before any cycle-N increment takes effect.
//  Tick: while EN=1, mtime increments by 1 on each tick. Arithmetic is modulo 2^48, so 48'hFFFF_FFFF_FFFF wraps to 0.
//  HI writes use bus_wdata[15:0]; bits [31:16] are ignored.
//  Write vs tick in the same cycle on an mtime half: the write wins and no increment occurs that cycle.
//   The other half holds (no carry from the suppressed tick).
//  timer_interrupt <= (mtime >= mtimecmp), unsigned 48-bit compare, registered on the current values.
//   One-cycle lag after any mtime/mtimecmp change.
//   Level signal, cleared only by raising mtimecmp or lowering mtime; not cleared by reads.
//  Wrap: after mtime wraps to 0, MTIP drops next cycle unless mtimecmp==0.
//  EN=0 freezes mtime (and the prescaler count). Registers stay writable and the compare stays live.
//  Reset asserted mid-operation: all state returns to reset values asynchronously.
//   Any pending response is dropped (rvalid=0).
//  Software must write MTIMECMP_HI=FFFF before updating LO, then HI, to avoid spurious MTIP.
// CONFIGURATION
//  MTIMER_PRESCALE_EN defined:
//   a 16-bit prescaler counts 0..PRESCALE-1 while EN=1 and ticks on wrap to 0.
//   Prescaler resets to 0 on rst_n and on any mtime write.
//  MTIMER_PRESCALE_EN undefined: tick every clk while EN=1; PRESCALE ignored, no prescaler flops.
// STRUCTURE
//  Shared header (soc package role, alongside debug_defines.vh):
//   MTIMER_OFF_* offsets, MTIMER_WIDTH=48, MTIMECMP_RST value, MTIP bit index 7 (shared with the CSR mip).
//  Sub-module rv32i_mtimer_prescaler (count, tick out, sync clear), instantiated only under MTIMER_PRESCALE_EN.
//  Top holds the bus decode, register file, 48-bit incrementer, comparator and response register.
// TESTING
//  Reset, then read 0x00 x3 with no prescaler -> rdata increases by 1 per cycle between reads.
//   MTIP=0 because mtimecmp reset is all ones.
//  Write MTIMECMP_HI=0, LO=20 while mtime~5 -> MTIP rises exactly 1 cycle after the mtime==20 cycle.
//   Write LO=FFFF_FFFF -> MTIP falls 1 cycle later.
//  Write MTIME_HI=FFFF, LO=FFFF_FFFE, mtimecmp=FFFF_FFFF_FFFF -> MTIP at max.
//   After the wrap, mtime==0 and MTIP drops.
//  Write MTIME_LO=100 in the same cycle as a tick -> next read returns 100+elapsed, with no +1 from the collision.
//  Read offset 0x14 -> rvalid=1, err=1, rdata=0. Write CTRL=0 -> mtime stable over 50 cycles; CTRL=1 resumes.
//  With MTIMER_PRESCALE_EN, PRESCALE=4: mtime increments once per 4 clks.
//   Write mid-count restarts the prescaler; pulse rst_n mid-run -> all outputs return to reset values.

Source files
------------

// File: rtl/rv32i_mtimer_pkg.sv
// Shared machine-timer definitions: register offsets, widths, reset values
// and the MTIP bit index (the same index the CSR file uses for mip).
package rv32i_mtimer_pkg;

  localparam int MTIMER_WIDTH = 48;
  localparam int MTIP_BIT     = 7;

  localparam logic [4:0] MTIMER_OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIMER_OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMER_OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMER_OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] MTIMER_OFF_CTRL        = 5'h10;

  localparam logic [MTIMER_WIDTH-1:0] MTIMECMP_RST = {MTIMER_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_CTRL,
    SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } bus_rsp_t;

  // Word-granular decode; byte-lane bits [1:0] do not take part.
  function automatic reg_sel_e decode_sel(input logic [4:0] addr);
    reg_sel_e s;
    case ({addr[4:2], 2'b00})
      MTIMER_OFF_MTIME_LO:    s = SEL_MTIME_LO;
      MTIMER_OFF_MTIME_HI:    s = SEL_MTIME_HI;
      MTIMER_OFF_MTIMECMP_LO: s = SEL_CMP_LO;
      MTIMER_OFF_MTIMECMP_HI: s = SEL_CMP_HI;
      MTIMER_OFF_CTRL:        s = SEL_CTRL;
      default:                s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rv32i_mtimer_if.sv
// Data-bus port of the machine timer: single-cycle request, response
// strobe exactly one cycle later, no backpressure.
interface rv32i_mtimer_if;
  logic        bus_req;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/rv32i_mtimer_prescaler.sv
// mtime tick prescaler: counts 0..PRESCALE-1 while enabled and issues a
// tick on the wrap back to 0. Compiled only when MTIMER_PRESCALE_EN is
// defined, so the default build carries no prescaler logic at all.
`ifdef MTIMER_PRESCALE_EN
module rv32i_mtimer_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count while enabled; an mtime write restarts the period from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= (cnt == LAST) ? 16'd0 : cnt + 16'd1;
  end
endmodule
`endif

// File: rtl/rv32i_mtimer.sv
// Machine timer: free-running 48-bit mtime, 48-bit mtimecmp, CTRL.EN, and
// the registered MTIP level (mtime >= mtimecmp) for the CSR file.
// Optional build macro: MTIMER_PRESCALE_EN (tick every PRESCALE clocks
// instead of every clock).
module rv32i_mtimer
  import rv32i_mtimer_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rv32i_mtimer_if.slave           bus,
  output logic [MTIMER_WIDTH-1:0] mtime,
  output logic                    timer_interrupt
);

  logic [MTIMER_WIDTH-1:0] mtimecmp;
  logic                    en;
  logic                    tick;
  reg_sel_e                sel;
  logic                    wr;
  logic                    wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;
  logic                    mtime_wr;
  logic [31:0]             rd_word;
  bus_rsp_t                rsp;
  logic                    unused_addr;

  assign unused_addr = ^bus.bus_addr[1:0];

  assign sel      = decode_sel(bus.bus_addr);
  assign wr       = bus.bus_req && bus.bus_we;
  assign wr_mlo   = wr && (sel == SEL_MTIME_LO);
  assign wr_mhi   = wr && (sel == SEL_MTIME_HI);
  assign wr_clo   = wr && (sel == SEL_CMP_LO);
  assign wr_chi   = wr && (sel == SEL_CMP_HI);
  assign wr_ctrl  = wr && (sel == SEL_CTRL);
  assign mtime_wr = wr_mlo || wr_mhi;

`ifdef MTIMER_PRESCALE_EN
  rv32i_mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (mtime_wr),
    .tick (tick)
  );
`else
  localparam int unused_prescale = PRESCALE;
  assign tick = en;
`endif

  // mtime: a write to either half wins over the tick and the other half
  // holds, so a colliding tick is simply lost (no carry either).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mtime <= '0;
    else if (wr_mlo) mtime <= {mtime[47:32], bus.bus_wdata};
    else if (wr_mhi) mtime <= {bus.bus_wdata[15:0], mtime[31:0]};
    else if (tick)   mtime <= mtime + 48'd1;
  end

  // mtimecmp and CTRL.EN: plain writable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= MTIMECMP_RST;
      en       <= 1'b1;
    end else begin
      if (wr_clo)  mtimecmp[31:0]  <= bus.bus_wdata;
      if (wr_chi)  mtimecmp[47:32] <= bus.bus_wdata[15:0];
      if (wr_ctrl) en              <= bus.bus_wdata[0];
    end
  end

  // MTIP compares the current register values, hence one cycle of lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_interrupt <= 1'b0;
    else        timer_interrupt <= (mtime >= mtimecmp);
  end

  // Read mux on pre-update state.
  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_MTIME_LO: rd_word = mtime[31:0];
      SEL_MTIME_HI: rd_word = {16'd0, mtime[47:32]};
      SEL_CMP_LO:   rd_word = mtimecmp[31:0];
      SEL_CMP_HI:   rd_word = {16'd0, mtimecmp[47:32]};
      SEL_CTRL:     rd_word = {31'd0, en};
      default:      rd_word = '0;
    endcase
  end

  // Response register: strobe every request, data only for good reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp <= '0;
    end else begin
      rsp.rvalid <= bus.bus_req;
      rsp.err    <= bus.bus_req && (sel == SEL_NONE);
      rsp.rdata  <= (bus.bus_req && !bus.bus_we && (sel != SEL_NONE)) ? rd_word : 32'd0;
    end
  end

  assign bus.bus_rvalid = rsp.rvalid;
  assign bus.bus_rdata  = rsp.rdata;
  assign bus.bus_err    = rsp.err;

endmodule

// File: tb/tb_rv32i_mtimer.sv
// Self-checking bench for rv32i_mtimer: directed steps plus a random
// phase, every cycle compared against a register-level reference model.
module tb_rv32i_mtimer;
  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] mtime;
  logic        irq;

  rv32i_mtimer_if bif();

  rv32i_mtimer #(.PRESCALE(PS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bif),
    .mtime          (mtime),
    .timer_interrupt(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, expressed directly as the architectural registers.
  logic [47:0] m_time, m_cmp;
  logic        m_en, m_irq, m_rv, m_err;
  logic [31:0] m_rd;
  int          m_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_time = '0; m_cmp = '1; m_en = 1'b1; m_irq = 1'b0;
    m_rv = 1'b0; m_err = 1'b0; m_rd = '0; m_pc = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rvalid"}, 64'(bif.bus_rvalid), 64'(m_rv));
    chk({tag, ".rdata"},  64'(bif.bus_rdata),  64'(m_rd));
    chk({tag, ".err"},    64'(bif.bus_err),    64'(m_err));
    chk({tag, ".mtime"},  64'(mtime),          64'(m_time));
    chk({tag, ".mtip"},   64'(irq),            64'(m_irq));
  endtask

  // One bus cycle: drive at negedge, let the edge happen, update the
  // model from the pre-edge state, then compare at the next negedge.
  task automatic step(input logic req, input logic we, input logic [4:0] addr,
                      input logic [31:0] wd, input string tag);
    int  w;
    logic tk;
    bif.bus_req = req; bif.bus_we = we; bif.bus_addr = addr; bif.bus_wdata = wd;
    @(posedge clk);
    w = int'(addr[4:2]);
    m_rv  = req;
    m_err = req && (w > 4);
    m_rd  = '0;
    if (req && !we) begin
      case (w)
        0: m_rd = m_time[31:0];
        1: m_rd = {16'd0, m_time[47:32]};
        2: m_rd = m_cmp[31:0];
        3: m_rd = {16'd0, m_cmp[47:32]};
        4: m_rd = {31'd0, m_en};
        default: m_rd = '0;
      endcase
    end
    m_irq = (m_time >= m_cmp);
`ifdef MTIMER_PRESCALE_EN
    tk = m_en && (m_pc == PS - 1);
`else
    tk = m_en;
`endif
    if (req && we && (w == 0 || w == 1)) begin
      if (w == 0) m_time[31:0]  = wd;
      else        m_time[47:32] = wd[15:0];
      m_pc = 0;
    end else begin
      if (tk) m_time = m_time + 48'd1;
      if (m_en) m_pc = (m_pc == PS - 1) ? 0 : m_pc + 1;
    end
    if (req && we && w == 2) m_cmp[31:0]  = wd;
    if (req && we && w == 3) m_cmp[47:32] = wd[15:0];
    if (req && we && w == 4) m_en = wd[0];
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'h00, 32'h0, tag);
  endtask

  logic [31:0] r0, r1;
  logic [4:0]  ra;

  initial begin
    bif.bus_req = 1'b0; bif.bus_we = 1'b0; bif.bus_addr = '0; bif.bus_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset_held");
    rst_n = 1'b1;
    idle(1, "post_reset");

    // Back-to-back reads of MTIME_LO advance by one tick per cycle.
    step(1'b1, 1'b0, 5'h00, 32'h0, "rd_lo_a"); r0 = bif.bus_rdata;
    step(1'b1, 1'b0, 5'h00, 32'h0, "rd_lo_b"); r1 = bif.bus_rdata;
    step(1'b1, 1'b0, 5'h00, 32'h0, "rd_lo_c");
`ifndef MTIMER_PRESCALE_EN
    chk("rd_lo_delta", 64'(r1 - r0), 64'd1);
    chk("rd_lo_delta2", 64'(bif.bus_rdata - r1), 64'd1);
`endif

    // Compare match at 20, then raise compare to drop MTIP.
    step(1'b1, 1'b1, 5'h0C, 32'h0, "wr_cmp_hi0");
    step(1'b1, 1'b1, 5'h08, 32'd20, "wr_cmp_lo20");
    idle(20 * ((`ifdef MTIMER_PRESCALE_EN PS `else 1 `endif)), "wait_match");
    chk("mtip_after_match", 64'(irq), 64'd1);
    step(1'b1, 1'b1, 5'h08, 32'hFFFF_FFFF, "wr_cmp_lo_max");
    idle(1, "mtip_fall");
    chk("mtip_fell", 64'(irq), 64'd0);

    // Near-max mtime, compare at max, then the wrap.
    step(1'b1, 1'b1, 5'h04, 32'hABCD_FFFF, "wr_mtime_hi");
    step(1'b1, 1'b1, 5'h0C, 32'h0000_FFFF, "wr_cmp_hi_max");
    step(1'b1, 1'b1, 5'h00, 32'hFFFF_FFFE, "wr_mtime_lo");
    idle(6 * ((`ifdef MTIMER_PRESCALE_EN PS `else 1 `endif)), "wrap");
    chk("mtime_wrapped_small", 64'(mtime < 48'd16), 64'd1);
    chk("mtip_after_wrap", 64'(irq), 64'd0);

    // Write colliding with a tick, then read back.
    step(1'b1, 1'b1, 5'h00, 32'd100, "wr_lo100");
    idle(3, "after_lo100");
    step(1'b1, 1'b0, 5'h00, 32'h0, "rd_lo100");

    // Undefined offsets, including byte-offset aliasing of a good one.
    step(1'b1, 1'b0, 5'h14, 32'h0, "rd_err14");
    step(1'b1, 1'b1, 5'h18, 32'hDEAD_BEEF, "wr_err18");
    step(1'b1, 1'b0, 5'h1F, 32'h0, "rd_err1f");
    step(1'b1, 1'b0, 5'h0B, 32'h0, "rd_cmp_lo_alias");

    // Freeze and resume.
    step(1'b1, 1'b1, 5'h10, 32'hFFFF_FFFE, "ctrl_off");
    step(1'b1, 1'b0, 5'h10, 32'h0, "rd_ctrl_off");
    idle(50, "frozen");
    step(1'b1, 1'b0, 5'h00, 32'h0, "rd_frozen");
    step(1'b1, 1'b1, 5'h10, 32'h1, "ctrl_on");
    step(1'b1, 1'b0, 5'h10, 32'h0, "rd_ctrl_on");
    idle(5, "resumed");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ra = 5'($urandom_range(0, 31));
      step(($urandom % 3) != 0, $urandom % 2 == 1, ra, $urandom, "rand");
    end

    // Force MTIP high and a pending response, then reset asynchronously.
    step(1'b1, 1'b1, 5'h10, 32'h1, "pre_rst_en");
    step(1'b1, 1'b1, 5'h0C, 32'h0, "pre_rst_cmp_hi");
    step(1'b1, 1'b1, 5'h08, 32'h0, "pre_rst_cmp_lo");
    step(1'b1, 1'b0, 5'h08, 32'h0, "pre_rst_rd");
    chk("pre_rst_mtip", 64'(irq), 64'd1);
    chk("pre_rst_rvalid", 64'(bif.bus_rvalid), 64'd1);
    bif.bus_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, "post_rst2");
    step(1'b1, 1'b0, 5'h0C, 32'h0, "rd_cmp_hi_rst");
    step(1'b1, 1'b0, 5'h10, 32'h0, "rd_ctrl_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
